// File: rtl/spu_pkg.sv
// Shared widths, encodings and slot helpers for the SPU dual-issue front end.
package spu_pkg;

  localparam int REG_W    = 7;
  localparam int ID_W     = 7;
  localparam int UNIT_W   = 3;
  localparam int LAT_W    = 4;
  localparam int NUM_REGS = 128;

  localparam logic [ID_W-1:0] NOP_ID = 7'd0;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PAIR,
    ST_SECOND
  } issue_state_e;

  typedef struct packed {
    logic [31:0]       full_instr;
    logic [ID_W-1:0]   instr_id;
    logic [REG_W-1:0]  reg_dst;
    logic [UNIT_W-1:0] unit_id;
    logic [LAT_W-1:0]  latency;
    logic              reg_wr;
    logic              pipe;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rc;
    logic [2:0]        src_used;
  } slot_t;

  typedef struct packed {
    logic [31:0]       full_instr;
    logic [ID_W-1:0]   instr_id;
    logic [REG_W-1:0]  reg_dst;
    logic [UNIT_W-1:0] unit_id;
    logic [LAT_W-1:0]  latency;
    logic              reg_wr;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rc;
  } issue_t;

  // A source counter of 1 reaches zero on this very edge, which is when the
  // producer's result becomes readable, so it does not block issue.
  function automatic logic slot_ok(slot_t s, logic [3:0][LAT_W-1:0] cnt);
    logic ok;
    ok = 1'b1;
    if (s.src_used[2] && cnt[0] > LAT_W'(1)) ok = 1'b0;
    if (s.src_used[1] && cnt[1] > LAT_W'(1)) ok = 1'b0;
    if (s.src_used[0] && cnt[2] > LAT_W'(1)) ok = 1'b0;
    if (s.reg_wr && cnt[3] > s.latency) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic reads_reg(slot_t s, logic [REG_W-1:0] r);
    return (s.src_used[2] && s.ra == r) ||
           (s.src_used[1] && s.rb == r) ||
           (s.src_used[0] && s.rc == r);
  endfunction

  function automatic issue_t to_issue(slot_t s);
    issue_t f;
    f.full_instr = s.full_instr;
    f.instr_id   = s.instr_id;
    f.reg_dst    = s.reg_dst;
    f.unit_id    = s.unit_id;
    f.latency    = s.latency;
    f.reg_wr     = s.reg_wr;
    f.ra         = s.ra;
    f.rb         = s.rb;
    f.rc         = s.rc;
    return f;
  endfunction

  function automatic issue_t nop_issue();
    issue_t f;
    f = '0;
    f.instr_id = NOP_ID;
    return f;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register result countdowns: two issue-time load ports and a bank of
// combinational read ports covering both held slots' sources and destinations.
module issue_scoreboard
  import spu_pkg::*;
#(
  parameter int NUM_RD = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      ld_en,
  input  logic [1:0][REG_W-1:0]           ld_addr,
  input  logic [1:0][LAT_W-1:0]           ld_val,
  input  logic [NUM_RD-1:0][REG_W-1:0]    rd_addr,
  output logic [NUM_RD-1:0][LAT_W-1:0]    rd_cnt
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];

  // A fresh load wins over the running decrement of the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_en[0] && ld_addr[0] == REG_W'(i))
          cnt_q[i] <= ld_val[0];
        else if (ld_en[1] && ld_addr[1] == REG_W'(i))
          cnt_q[i] <= ld_val[1];
        else if (cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rd_cnt[p] = cnt_q[rd_addr[p]];
  end

endmodule

// File: rtl/dep_check_issue.sv
// Dual-issue dependency check: holds one program-ordered pair, resolves hazards
// against the scoreboard and within the pair, and drives registered pipe fields.
module dep_check_issue
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [31:0]       s0_full_instr,
  input  logic [31:0]       s1_full_instr,
  input  logic [ID_W-1:0]   s0_instr_id,
  input  logic [ID_W-1:0]   s1_instr_id,
  input  logic [REG_W-1:0]  s0_reg_dst,
  input  logic [REG_W-1:0]  s1_reg_dst,
  input  logic [UNIT_W-1:0] s0_unit_id,
  input  logic [UNIT_W-1:0] s1_unit_id,
  input  logic [LAT_W-1:0]  s0_latency,
  input  logic [LAT_W-1:0]  s1_latency,
  input  logic              s0_reg_wr,
  input  logic              s1_reg_wr,
  input  logic              s0_pipe,
  input  logic              s1_pipe,
  input  logic [REG_W-1:0]  s0_ra_addr,
  input  logic [REG_W-1:0]  s0_rb_addr,
  input  logic [REG_W-1:0]  s0_rc_addr,
  input  logic [REG_W-1:0]  s1_ra_addr,
  input  logic [REG_W-1:0]  s1_rb_addr,
  input  logic [REG_W-1:0]  s1_rc_addr,
  input  logic [2:0]        s0_src_used,
  input  logic [2:0]        s1_src_used,
  output logic [31:0]       full_instr_even,
  output logic [31:0]       full_instr_odd,
  output logic [ID_W-1:0]   instr_id_even,
  output logic [ID_W-1:0]   instr_id_odd,
  output logic [REG_W-1:0]  reg_dst_even,
  output logic [REG_W-1:0]  reg_dst_odd,
  output logic [UNIT_W-1:0] unit_id_even,
  output logic [UNIT_W-1:0] unit_id_odd,
  output logic [LAT_W-1:0]  latency_even,
  output logic [LAT_W-1:0]  latency_odd,
  output logic              reg_wr_even,
  output logic              reg_wr_odd,
  output logic [REG_W-1:0]  ra_addr_even,
  output logic [REG_W-1:0]  rb_addr_even,
  output logic [REG_W-1:0]  rc_addr_even,
  output logic [REG_W-1:0]  ra_addr_odd,
  output logic [REG_W-1:0]  rb_addr_odd,
  output logic [REG_W-1:0]  rc_addr_odd,
  output logic              stall
);

  issue_state_e state_q, state_d;
  slot_t        in0, in1, s0_q, s1_q;
  issue_t       even_q, odd_q, even_d, odd_d;

  logic s0_ok, s1_ok, pair_legal;
  logic want0, want1, issue0, issue1, drained, accept;

  logic [7:0][REG_W-1:0] rd_addr;
  logic [7:0][LAT_W-1:0] rd_cnt;

  assign in0 = '{full_instr: s0_full_instr, instr_id: s0_instr_id, reg_dst: s0_reg_dst,
                 unit_id: s0_unit_id, latency: s0_latency, reg_wr: s0_reg_wr,
                 pipe: s0_pipe, ra: s0_ra_addr, rb: s0_rb_addr, rc: s0_rc_addr,
                 src_used: s0_src_used};
  assign in1 = '{full_instr: s1_full_instr, instr_id: s1_instr_id, reg_dst: s1_reg_dst,
                 unit_id: s1_unit_id, latency: s1_latency, reg_wr: s1_reg_wr,
                 pipe: s1_pipe, ra: s1_ra_addr, rb: s1_rb_addr, rc: s1_rc_addr,
                 src_used: s1_src_used};

  assign rd_addr = {s1_q.reg_dst, s1_q.rc, s1_q.rb, s1_q.ra,
                    s0_q.reg_dst, s0_q.rc, s0_q.rb, s0_q.ra};

  issue_scoreboard #(.NUM_RD(8)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .ld_en   ({issue1 && s1_q.reg_wr, issue0 && s0_q.reg_wr}),
    .ld_addr ({s1_q.reg_dst, s0_q.reg_dst}),
    .ld_val  ({s1_q.latency, s0_q.latency}),
    .rd_addr (rd_addr),
    .rd_cnt  (rd_cnt)
  );

  assign s0_ok = slot_ok(s0_q, rd_cnt[3:0]);
  assign s1_ok = slot_ok(s1_q, rd_cnt[7:4]);

  // Co-issue also needs distinct pipes and no RAW/WAW between the two slots.
  assign pair_legal = s1_ok && (s1_q.pipe != s0_q.pipe) &&
                      !(s0_q.reg_wr && reads_reg(s1_q, s0_q.reg_dst)) &&
                      !(s0_q.reg_wr && s1_q.reg_wr && s0_q.reg_dst == s1_q.reg_dst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    want0 = 1'b0;
    want1 = 1'b0;
    case (state_q)
      ST_PAIR: begin
        want0 = s0_ok;
        want1 = s0_ok && pair_legal;
      end
      ST_SECOND: want1 = s1_ok;
      default: ;
    endcase

    drained  = (state_q == ST_EMPTY) || want1;
    in_ready = drained && !flush;
    accept   = in_valid && in_ready;
    issue0   = want0 && !flush;
    issue1   = want1 && !flush;
    stall    = (state_q != ST_EMPTY) && !want0 && !want1;

    state_d = state_q;
    if (flush)        state_d = ST_EMPTY;
    else if (accept)  state_d = ST_PAIR;
    else if (drained) state_d = ST_EMPTY;
    else if (want0)   state_d = ST_SECOND;

    even_d = nop_issue();
    odd_d  = nop_issue();
    if (issue0 && s0_q.pipe == PIPE_EVEN) even_d = to_issue(s0_q);
    if (issue0 && s0_q.pipe == PIPE_ODD)  odd_d  = to_issue(s0_q);
    if (issue1 && s1_q.pipe == PIPE_EVEN) even_d = to_issue(s1_q);
    if (issue1 && s1_q.pipe == PIPE_ODD)  odd_d  = to_issue(s1_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      even_q <= nop_issue();
      odd_q  <= nop_issue();
    end else begin
      if (accept) begin
        s0_q <= in0;
        s1_q <= in1;
      end
      even_q <= even_d;
      odd_q  <= odd_d;
    end
  end

  assign full_instr_even = even_q.full_instr;
  assign instr_id_even   = even_q.instr_id;
  assign reg_dst_even    = even_q.reg_dst;
  assign unit_id_even    = even_q.unit_id;
  assign latency_even    = even_q.latency;
  assign reg_wr_even     = even_q.reg_wr;
  assign ra_addr_even    = even_q.ra;
  assign rb_addr_even    = even_q.rb;
  assign rc_addr_even    = even_q.rc;
  assign full_instr_odd  = odd_q.full_instr;
  assign instr_id_odd    = odd_q.instr_id;
  assign reg_dst_odd     = odd_q.reg_dst;
  assign unit_id_odd     = odd_q.unit_id;
  assign latency_odd     = odd_q.latency;
  assign reg_wr_odd      = odd_q.reg_wr;
  assign ra_addr_odd     = odd_q.ra;
  assign rb_addr_odd     = odd_q.rb;
  assign rc_addr_odd     = odd_q.rc;

endmodule

// File: tb/tb_dep_check_issue.sv
// Self-checking bench for dep_check_issue: directed hazard scenarios followed by
// random pairs, all predicted by a time-based readiness model of the registers.
module tb_dep_check_issue;

  typedef struct {
    logic [31:0] word;
    int          id, dst, unit, lat;
    bit          wr, pipe;
    int          src[3];
    bit [2:0]    used;
  } instr_t;

  logic clk = 1'b0;
  logic rst, in_valid, flush, in_ready, stall;
  logic [31:0] s0_full_instr, s1_full_instr, full_instr_even, full_instr_odd;
  logic [6:0]  s0_instr_id, s1_instr_id, s0_reg_dst, s1_reg_dst;
  logic [2:0]  s0_unit_id, s1_unit_id, s0_src_used, s1_src_used;
  logic [3:0]  s0_latency, s1_latency;
  logic        s0_reg_wr, s1_reg_wr, s0_pipe, s1_pipe;
  logic [6:0]  s0_ra_addr, s0_rb_addr, s0_rc_addr, s1_ra_addr, s1_rb_addr, s1_rc_addr;
  logic [6:0]  instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd;
  logic [2:0]  unit_id_even, unit_id_odd;
  logic [3:0]  latency_even, latency_odd;
  logic        reg_wr_even, reg_wr_odd;
  logic [6:0]  ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd;

  int n_cmp = 0;
  int n_fail = 0;
  int e_now = 1;
  int ready_at [128];
  int seen_edge [128];
  int held_n = 0;
  int stall_cnt = 0;
  int acc_edge;
  instr_t held0, held1, nx0, nx1;

  dep_check_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .s0_full_instr(s0_full_instr), .s1_full_instr(s1_full_instr),
    .s0_instr_id(s0_instr_id), .s1_instr_id(s1_instr_id),
    .s0_reg_dst(s0_reg_dst), .s1_reg_dst(s1_reg_dst),
    .s0_unit_id(s0_unit_id), .s1_unit_id(s1_unit_id),
    .s0_latency(s0_latency), .s1_latency(s1_latency),
    .s0_reg_wr(s0_reg_wr), .s1_reg_wr(s1_reg_wr),
    .s0_pipe(s0_pipe), .s1_pipe(s1_pipe),
    .s0_ra_addr(s0_ra_addr), .s0_rb_addr(s0_rb_addr), .s0_rc_addr(s0_rc_addr),
    .s1_ra_addr(s1_ra_addr), .s1_rb_addr(s1_rb_addr), .s1_rc_addr(s1_rc_addr),
    .s0_src_used(s0_src_used), .s1_src_used(s1_src_used),
    .full_instr_even(full_instr_even), .full_instr_odd(full_instr_odd),
    .instr_id_even(instr_id_even), .instr_id_odd(instr_id_odd),
    .reg_dst_even(reg_dst_even), .reg_dst_odd(reg_dst_odd),
    .unit_id_even(unit_id_even), .unit_id_odd(unit_id_odd),
    .latency_even(latency_even), .latency_odd(latency_odd),
    .reg_wr_even(reg_wr_even), .reg_wr_odd(reg_wr_odd),
    .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even), .rc_addr_even(rc_addr_even),
    .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd), .rc_addr_odd(rc_addr_odd),
    .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(int id, bit pipe, int dst, bit wr, int lat,
                                bit [2:0] used, int ra, int rb, int rc);
    instr_t t;
    t.word = $urandom;
    t.id = id; t.pipe = pipe; t.dst = dst; t.wr = wr; t.lat = lat;
    t.unit = id % 8; t.used = used;
    t.src[0] = ra; t.src[1] = rb; t.src[2] = rc;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    return mk($urandom_range(1, 127), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), $urandom_range(2, 9), 3'($urandom_range(0, 7)),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endfunction

  function automatic logic [79:0] fields(instr_t t);
    return {5'b0, t.word, 7'(t.id), 7'(t.dst), 3'(t.unit), 4'(t.lat), t.wr,
            7'(t.src[0]), 7'(t.src[1]), 7'(t.src[2])};
  endfunction

  function automatic logic [79:0] nop_fields();
    return {5'b0, 32'b0, 7'd0, 36'b0};
  endfunction

  // Readable at edge E once every used source's result time has arrived, and an
  // older write to the same destination must complete strictly before this one.
  function automatic bit can_go(instr_t t);
    bit ok = 1'b1;
    for (int k = 0; k < 3; k++)
      if (t.used[2-k] && ready_at[t.src[k]] > e_now) ok = 1'b0;
    if (t.wr && ready_at[t.dst] >= e_now + t.lat) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit reads(instr_t t, int r);
    bit hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (t.used[2-k] && t.src[k] == r) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit pair_legal(instr_t a, instr_t b);
    return (a.pipe != b.pipe) && !(a.wr && reads(b, a.dst)) &&
           !(a.wr && b.wr && a.dst == b.dst);
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic route(instr_t t, inout logic [79:0] e, inout logic [79:0] o);
    if (t.pipe) o = fields(t);
    else        e = fields(t);
    if (t.wr) ready_at[t.dst] = e_now + t.lat;
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // then check the registered pipe fields just after the rising edge.
  task automatic applyStimulus(input bit v, input bit fl);
    bit i0, i1, exp_rdy, exp_stall;
    logic [79:0] exp_e, exp_o;
    in_valid = v; flush = fl;
    s0_full_instr = nx0.word; s0_instr_id = 7'(nx0.id); s0_reg_dst = 7'(nx0.dst);
    s0_unit_id = 3'(nx0.unit); s0_latency = 4'(nx0.lat); s0_reg_wr = nx0.wr;
    s0_pipe = nx0.pipe; s0_src_used = nx0.used; s0_ra_addr = 7'(nx0.src[0]);
    s0_rb_addr = 7'(nx0.src[1]); s0_rc_addr = 7'(nx0.src[2]);
    s1_full_instr = nx1.word; s1_instr_id = 7'(nx1.id); s1_reg_dst = 7'(nx1.dst);
    s1_unit_id = 3'(nx1.unit); s1_latency = 4'(nx1.lat); s1_reg_wr = nx1.wr;
    s1_pipe = nx1.pipe; s1_src_used = nx1.used; s1_ra_addr = 7'(nx1.src[0]);
    s1_rb_addr = 7'(nx1.src[1]); s1_rc_addr = 7'(nx1.src[2]);
    #1;
    i0 = 1'b0; i1 = 1'b0;
    if (held_n == 2) begin
      i0 = can_go(held0);
      i1 = i0 && can_go(held1) && pair_legal(held0, held1);
    end else if (held_n == 1) begin
      i1 = can_go(held1);
    end
    exp_stall = (held_n != 0) && !i0 && !i1;
    exp_rdy = !fl && (held_n == 0 || i1);
    checkOutput("in_ready", 80'(in_ready), 80'(exp_rdy));
    checkOutput("stall", 80'(stall), 80'(exp_stall));
    if (stall === 1'b1) stall_cnt++;
    exp_e = nop_fields(); exp_o = nop_fields();
    if (fl) held_n = 0;
    else begin
      if (i0) route(held0, exp_e, exp_o);
      if (i1) route(held1, exp_e, exp_o);
      if (i1) held_n = 0;
      else if (i0) held_n = 1;
    end
    if (v && exp_rdy) begin
      held0 = nx0; held1 = nx1; held_n = 2;
    end
    @(posedge clk); #1;
    checkOutput("even_pipe", {5'b0, full_instr_even, instr_id_even, reg_dst_even, unit_id_even,
                latency_even, reg_wr_even, ra_addr_even, rb_addr_even, rc_addr_even}, exp_e);
    checkOutput("odd_pipe", {5'b0, full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd,
                latency_odd, reg_wr_odd, ra_addr_odd, rb_addr_odd, rc_addr_odd}, exp_o);
    if (instr_id_even != 7'd0) seen_edge[instr_id_even] = e_now;
    if (instr_id_odd != 7'd0) seen_edge[instr_id_odd] = e_now;
    e_now++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_even"}, {5'b0, full_instr_even, instr_id_even, reg_dst_even, unit_id_even,
                latency_even, reg_wr_even, ra_addr_even, rb_addr_even, rc_addr_even}, nop_fields());
    checkOutput({tag, "_odd"}, {5'b0, full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd,
                latency_odd, reg_wr_odd, ra_addr_odd, rb_addr_odd, rc_addr_odd}, nop_fields());
    checkOutput({tag, "_stall"}, 80'(stall), 80'(0));
    checkOutput({tag, "_in_ready"}, 80'(in_ready), 80'(1));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    for (int r = 0; r < 128; r++) begin ready_at[r] = 0; seen_edge[r] = -1; end
    nx0 = mk(1, 0, 0, 0, 2, 3'b000, 0, 0, 0);
    nx1 = nx0;
    repeat (2) @(negedge clk);
    #1 checkResetState("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] independent pair");
    nx0 = mk(1, 0, 2, 1, 4, 3'b000, 0, 0, 0);
    nx1 = mk(2, 1, 9, 0, 3, 3'b100, 5, 0, 0);
    acc_edge = e_now;
    applyStimulus(1'b1, 1'b0);
    idle(1);
    checkOutput("indep_s0_edge", 80'(seen_edge[1]), 80'(acc_edge + 1));
    checkOutput("indep_s1_edge", 80'(seen_edge[2]), 80'(acc_edge + 1));
    idle(6);

    $display("[TB] intra-pair RAW");
    nx0 = mk(3, 0, 2, 1, 6, 3'b000, 0, 0, 0);
    nx1 = mk(4, 1, 11, 1, 3, 3'b100, 2, 0, 0);
    applyStimulus(1'b1, 1'b0);
    stall_cnt = 0;
    idle(9);
    checkOutput("raw_gap", 80'(seen_edge[4] - seen_edge[3]), 80'(6));
    checkOutput("raw_stall_cycles", 80'(stall_cnt), 80'(5));

    $display("[TB] structural");
    nx0 = mk(5, 0, 12, 1, 2, 3'b000, 0, 0, 0);
    nx1 = mk(6, 0, 13, 1, 2, 3'b010, 0, 7, 0);
    applyStimulus(1'b1, 1'b0);
    nx0 = mk(7, 1, 14, 0, 2, 3'b000, 0, 0, 0);
    nx1 = mk(8, 0, 15, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(4);
    checkOutput("struct_gap", 80'(seen_edge[6] - seen_edge[5]), 80'(1));

    $display("[TB] scoreboard RAW across pairs");
    nx0 = mk(9, 0, 10, 1, 7, 3'b000, 0, 0, 0);
    nx1 = mk(10, 1, 16, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    nx0 = mk(11, 0, 17, 1, 2, 3'b001, 0, 0, 10);
    nx1 = mk(12, 1, 18, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    idle(10);
    checkOutput("sb_raw_gap", 80'(seen_edge[11] - seen_edge[9]), 80'(7));

    $display("[TB] flush during stall");
    nx0 = mk(13, 0, 30, 1, 9, 3'b000, 0, 0, 0);
    nx1 = mk(14, 1, 19, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    nx0 = mk(15, 0, 21, 1, 3, 3'b100, 30, 0, 0);
    nx1 = mk(16, 1, 22, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1);
    idle(1);
    checkOutput("flushed_not_issued", 80'(seen_edge[15]), 80'(-1));
    nx0 = mk(17, 0, 23, 0, 2, 3'b100, 21, 0, 0);
    nx1 = mk(18, 1, 24, 0, 2, 3'b000, 0, 0, 0);
    acc_edge = e_now;
    applyStimulus(1'b1, 1'b0);
    idle(10);
    checkOutput("after_flush_edge", 80'(seen_edge[17]), 80'(acc_edge + 1));

    $display("[TB] async reset mid-stall");
    nx0 = mk(19, 0, 40, 1, 12, 3'b000, 0, 0, 0);
    nx1 = mk(20, 1, 25, 0, 2, 3'b000, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    nx0 = mk(21, 0, 41, 1, 3, 3'b100, 40, 0, 0);
    nx1 = mk(22, 1, 26, 0, 2, 3'b100, 40, 0, 0);
    applyStimulus(1'b1, 1'b0);
    idle(2);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1 checkResetState("midreset");
    @(negedge clk);
    rst = 1'b1;
    held_n = 0;
    for (int r = 0; r < 128; r++) ready_at[r] = 0;
    nx0 = mk(23, 0, 42, 1, 3, 3'b100, 40, 0, 0);
    nx1 = mk(24, 1, 43, 0, 2, 3'b001, 0, 0, 40);
    acc_edge = e_now;
    applyStimulus(1'b1, 1'b0);
    idle(1);
    checkOutput("post_reset_s0", 80'(seen_edge[23]), 80'(acc_edge + 1));
    checkOutput("post_reset_s1", 80'(seen_edge[24]), 80'(acc_edge + 1));
    idle(4);

    $display("[TB] random pairs");
    for (int n = 0; n < 400; n++) begin
      nx0 = rand_instr();
      nx1 = rand_instr();
      applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
